tl_fifo_flow: RTL and testbench

//   Synchronous FIFO with threshold-driven flow-control flags for the PCIe transaction layer.
//   The transaction-layer control FSM drives sup_Threshold/inf_Threshold into this block
//   and consumes its empty flag (one bit of the FSM's `empties` vector per FIFO instance).

---
 rtl/tl_fifo_flow_if.sv | 32 +++
 rtl/tl_fifo_flow.sv | 91 +++++++++
 tb/tb_tl_fifo_flow.sv | 134 +++++++++++++
 3 files changed

// File: rtl/tl_fifo_flow_if.sv
// rtl/tl_fifo_flow_if.sv - push/pop, threshold and status bundle for one virtual-channel FIFO
interface tl_fifo_flow_if #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] sup_Threshold;
  logic [ADDR_WIDTH-1:0] inf_Threshold;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  pause;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, data_in, rd_en, sup_Threshold, inf_Threshold,
    input  data_out, valid_out, empty, full, almost_full, almost_empty,
           pause, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, sup_Threshold, inf_Threshold,
    output data_out, valid_out, empty, full, almost_full, almost_empty,
           pause, overflow, underflow
  );
endinterface

// File: rtl/tl_fifo_flow.sv
// rtl/tl_fifo_flow.sv - synchronous FIFO with threshold flags and hysteretic pause request
module tl_fifo_flow #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3
) (
  input  logic          clk,
  input  logic          reset,
  tl_fifo_flow_if.slave bus
);
  localparam int            CW      = ADDR_WIDTH + 1;
  localparam int            DEPTH_N = 1 << ADDR_WIDTH;
  localparam logic [CW-1:0] DEPTH   = CW'(DEPTH_N);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_N];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;
  logic                  r_pause;
  logic                  r_overflow;
  logic                  r_underflow;

  logic          w_empty;
  logic          w_full;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_sup;
  logic [CW-1:0] w_inf;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == DEPTH);
  assign w_sup    = CW'(bus.sup_Threshold);
  assign w_inf    = CW'(bus.inf_Threshold);
  // A read on a full FIFO frees the slot the concurrent write lands in.
  assign w_wr_acc = bus.wr_en && (!w_full || bus.rd_en);
  assign w_rd_acc = bus.rd_en && !w_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc)
      w_count_nxt = r_count + CW'(1);
    else if (!w_wr_acc && w_rd_acc)
      w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc)
      r_mem[r_wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_pause     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_overflow  <= bus.wr_en && w_full && !bus.rd_en;
      r_underflow <= bus.rd_en && w_empty;
      r_valid_out <= w_rd_acc;
      if (w_wr_acc)
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_rd_acc) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      // Set has priority so a degenerate inf >= sup setting still throttles.
      if (w_count_nxt >= w_sup)
        r_pause <= 1'b1;
      else if (w_count_nxt <= w_inf)
        r_pause <= 1'b0;
    end
  end

  assign bus.data_out     = r_data_out;
  assign bus.valid_out    = r_valid_out;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_full  = (r_count >= w_sup);
  assign bus.almost_empty = (r_count <= w_inf);
  assign bus.pause        = r_pause;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_tl_fifo_flow.sv
// tb/tb_tl_fifo_flow.sv - scoreboard bench for tl_fifo_flow
module tb_tl_fifo_flow;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  logic [9:0] m_q [$];
  logic [9:0] exp_q [$];
  logic       m_pause;

  tl_fifo_flow_if #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) bus ();

  tl_fifo_flow #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_flags();
    int c;
    c = m_q.size();
    check("empty", 32'(bus.empty), 32'(c == 0));
    check("full", 32'(bus.full), 32'(c == 8));
    check("almost_full", 32'(bus.almost_full), 32'(c >= int'(bus.sup_Threshold)));
    check("almost_empty", 32'(bus.almost_empty), 32'(c <= int'(bus.inf_Threshold)));
    check("pause", 32'(bus.pause), 32'(m_pause));
  endtask

  task automatic step(input logic wr, input logic [9:0] din, input logic rd);
    bit full_m, empty_m, wr_acc, rd_acc, exp_ovf, exp_udf;
    int n;
    @(negedge clk);
    bus.wr_en   = wr;
    bus.data_in = din;
    bus.rd_en   = rd;
    full_m  = (m_q.size() == 8);
    empty_m = (m_q.size() == 0);
    wr_acc  = wr && (!full_m || rd);
    rd_acc  = rd && !empty_m;
    exp_ovf = wr && full_m && !rd;
    exp_udf = rd && empty_m;
    if (rd_acc) exp_q.push_back(m_q.pop_front());
    if (wr_acc) m_q.push_back(din);
    n = m_q.size();
    if (n >= int'(bus.sup_Threshold)) m_pause = 1'b1;
    else if (n <= int'(bus.inf_Threshold)) m_pause = 1'b0;
    @(posedge clk);
    #1;
    check("valid_out", 32'(bus.valid_out), 32'(rd_acc));
    if (bus.valid_out) begin
      if (exp_q.size() == 0) check("sb_extra", 32'd1, 32'd0);
      else check("data_out", 32'(bus.data_out), 32'(exp_q.pop_front()));
    end
    check("overflow", 32'(bus.overflow), 32'(exp_ovf));
    check("underflow", 32'(bus.underflow), 32'(exp_udf));
    check_flags();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(bus.valid_out), 32'd0);
    check({tag, "_data"}, 32'(bus.data_out), 32'd0);
    check({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
    check({tag, "_udf"}, 32'(bus.underflow), 32'd0);
    check_flags();
  endtask

  initial begin
    n_chk = 0; n_pass = 0; m_pause = 1'b0;
    reset = 1'b0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.data_in = '0;
    bus.sup_Threshold = 3'd6; bus.inf_Threshold = 3'd2;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    @(negedge clk);
    reset = 1'b1;

    // Fill, then one write too many.
    for (int i = 1; i <= 8; i++) step(1'b1, 10'(i), 1'b0);
    step(1'b1, 10'h3FF, 1'b0);

    // Drain in order.
    for (int i = 0; i < 8; i++) step(1'b0, 10'h0, 1'b1);

    // Refill, simultaneous read/write at full, drain across pointer wrap.
    for (int i = 0; i < 8; i++) step(1'b1, 10'(10'h011 + i), 1'b0);
    step(1'b1, 10'h2AA, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 10'h0, 1'b1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    // Simultaneous read/write on empty: write only, underflow.
    step(1'b1, 10'h155, 1'b1);
    step(1'b0, 10'h0, 1'b1);

    // Mid-burst asynchronous reset.
    for (int i = 0; i < 5; i++) step(1'b1, 10'(10'h0A0 + i), 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    m_q.delete(); exp_q.delete(); m_pause = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 10'h0, 1'b1);

    // Degenerate thresholds then random traffic.
    bus.sup_Threshold = 3'd3; bus.inf_Threshold = 3'd5;
    for (int i = 0; i < 150; i++)
      step(1'($urandom_range(0, 1)), 10'($urandom), 1'($urandom_range(0, 2) == 0));
    bus.sup_Threshold = 3'd5; bus.inf_Threshold = 3'd1;
    for (int i = 0; i < 150; i++)
      step(1'($urandom_range(0, 2) != 0), 10'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 10; i++) step(1'b0, 10'h0, 1'b1);
    check("sb_final", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
